// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the boot loader: the loader state encoding and the
// fixed size of the word-count header that precedes every image.
// -----------------------------------------------------------------------------
package loader_pkg;

    typedef enum logic [2:0] {
        LD_HEADER,
        LD_PAYLOAD,
        LD_CHECK,
        LD_RUN,
        LD_ERROR
    } loader_state_t;

    localparam int HEADER_BYTES = 4;

endpackage

// File: rtl/byte_packer.sv
// -----------------------------------------------------------------------------
// byte_packer
// Assembles a stream of bytes into WORD_BYTES-wide words. With BIG_ENDIAN the
// first byte of a word ends up in the most significant byte, otherwise in the
// least significant byte.
//
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-high reset
//   clear      - synchronous clear, drops any partially assembled word
//   byte_valid - byte_in is consumed this cycle
//   byte_in    - incoming byte
//   word_done  - combinational: this byte completes a word
//   word_out   - combinational: the word including this cycle's byte
// -----------------------------------------------------------------------------
module byte_packer #(
    parameter int WORD_BYTES = 4,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    byte_valid,
    input  logic [7:0]              byte_in,
    output logic                    word_done,
    output logic [8*WORD_BYTES-1:0] word_out
);

    localparam int WORD_W = 8 * WORD_BYTES;
    localparam int IDX_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    logic [WORD_W-1:0] shift_reg;
    logic [WORD_W-1:0] shift_next;
    logic [IDX_W-1:0]  byte_idx;
    logic              last_byte;

    // Big-endian shifts left and appends at the bottom; little-endian shifts
    // right and inserts at the top, so the first byte drifts down to the LSB.
    always_comb begin
        if (BIG_ENDIAN) begin
            shift_next = (shift_reg << 8) | WORD_W'(byte_in);
        end else begin
            shift_next = (shift_reg >> 8) | (WORD_W'(byte_in) << (8 * (WORD_BYTES - 1)));
        end
    end

    assign last_byte = (byte_idx == IDX_W'(WORD_BYTES - 1));
    assign word_done = byte_valid && last_byte;
    assign word_out  = shift_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
            byte_idx  <= '0;
        end else if (clear) begin
            shift_reg <= '0;
            byte_idx  <= '0;
        end else if (byte_valid) begin
            shift_reg <= shift_next;
            byte_idx  <= last_byte ? '0 : byte_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/boot_loader.sv
// -----------------------------------------------------------------------------
// boot_loader
// Receives a framed program image from the RX FIFO (big-endian 32-bit word
// count, payload bytes, optional 8-bit additive checksum), packs the payload
// into instruction words, writes them to consecutive instruction-memory
// addresses and raises in_execution once the image is complete and verified.
//
// Ports:
//   clk, reset      - clock and asynchronous active-high reset
//   restart         - synchronous pulse, abandons the load and waits for a header
//   rx_valid/rx_data- head byte of the RX FIFO
//   rx_pop          - combinational, head byte consumed this cycle
//   write_enable    - registered one-cycle instruction-memory write strobe
//   write_address   - registered word address
//   write_data      - registered packed word
//   in_execution    - registered, image loaded and verified
//   load_error      - registered, oversize header or checksum mismatch
//   words_loaded    - registered count of words written (one extra bit so a
//                     full 2^ADDR_WIDTH image does not wrap)
// -----------------------------------------------------------------------------
module boot_loader #(
    parameter int WORD_BYTES = 4,
    parameter int ADDR_WIDTH = 16,
    parameter bit BIG_ENDIAN = 1'b1,
    parameter bit CHECKSUM   = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    restart,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data,
    output logic                    rx_pop,
    output logic                    write_enable,
    output logic [ADDR_WIDTH-1:0]   write_address,
    output logic [8*WORD_BYTES-1:0] write_data,
    output logic                    in_execution,
    output logic                    load_error,
    output logic [ADDR_WIDTH:0]     words_loaded
);

    import loader_pkg::*;

    localparam int          HDR_W     = 8 * HEADER_BYTES;
    localparam int          HC_W      = $clog2(HEADER_BYTES);
    localparam logic [32:0] MAX_WORDS = 33'(1) << ADDR_WIDTH;

    loader_state_t             state;
    logic [HDR_W-9:0]          header_shift;
    logic [HDR_W-1:0]          header_next;
    logic [HC_W-1:0]           header_cnt;
    logic [ADDR_WIDTH:0]       word_target;
    logic [ADDR_WIDTH:0]       words_next;
    logic [7:0]                sum;
    logic                      packer_valid;
    logic                      word_done;
    logic [8*WORD_BYTES-1:0]   packed_word;

    // restart takes priority over the FIFO so a byte present during restart
    // stays in the FIFO and becomes the first header byte afterwards.
    assign rx_pop = rx_valid && !restart &&
                    (state inside {LD_HEADER, LD_PAYLOAD, LD_CHECK});

    assign packer_valid = rx_pop && (state == LD_PAYLOAD);
    assign header_next  = {header_shift, rx_data};
    assign words_next   = words_loaded + (ADDR_WIDTH + 1)'(1);

    byte_packer #(
        .WORD_BYTES (WORD_BYTES),
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (restart),
        .byte_valid (packer_valid),
        .byte_in    (rx_data),
        .word_done  (word_done),
        .word_out   (packed_word)
    );

    // Loader FSM with all outputs registered. The header count is compared on
    // a 33-bit scale so a count of exactly 2^ADDR_WIDTH is accepted. The
    // words-loaded counter doubles as the write address of the next word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= LD_HEADER;
            header_shift  <= '0;
            header_cnt    <= '0;
            word_target   <= '0;
            sum           <= '0;
            write_enable  <= 1'b0;
            write_address <= '0;
            write_data    <= '0;
            in_execution  <= 1'b0;
            load_error    <= 1'b0;
            words_loaded  <= '0;
        end else begin
            write_enable <= 1'b0;
            if (restart) begin
                state        <= LD_HEADER;
                header_shift <= '0;
                header_cnt   <= '0;
                word_target  <= '0;
                sum          <= '0;
                in_execution <= 1'b0;
                load_error   <= 1'b0;
                words_loaded <= '0;
            end else if (rx_pop) begin
                case (state)
                    LD_HEADER: begin
                        header_shift <= header_next[HDR_W-9:0];
                        header_cnt   <= header_cnt + HC_W'(1);
                        if (header_cnt == HC_W'(HEADER_BYTES - 1)) begin
                            header_cnt  <= '0;
                            word_target <= (ADDR_WIDTH + 1)'(header_next);
                            if ({1'b0, header_next} > MAX_WORDS) begin
                                state      <= LD_ERROR;
                                load_error <= 1'b1;
                            end else if (header_next == '0) begin
                                if (CHECKSUM) begin
                                    state <= LD_CHECK;
                                end else begin
                                    state        <= LD_RUN;
                                    in_execution <= 1'b1;
                                end
                            end else begin
                                state <= LD_PAYLOAD;
                            end
                        end
                    end
                    LD_PAYLOAD: begin
                        sum <= sum + rx_data;
                        if (word_done) begin
                            write_enable  <= 1'b1;
                            write_address <= words_loaded[ADDR_WIDTH-1:0];
                            write_data    <= packed_word;
                            words_loaded  <= words_next;
                            if (words_next == word_target) begin
                                if (CHECKSUM) begin
                                    state <= LD_CHECK;
                                end else begin
                                    state        <= LD_RUN;
                                    in_execution <= 1'b1;
                                end
                            end
                        end
                    end
                    LD_CHECK: begin
                        if (rx_data == sum) begin
                            state        <= LD_RUN;
                            in_execution <= 1'b1;
                        end else begin
                            state      <= LD_ERROR;
                            load_error <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_boot_loader
// Drives two loaders: the default configuration (big-endian, checksum,
// 16-bit addresses) and a small one (little-endian, no checksum, 4-bit
// addresses) so the full-memory boundary can be reached. Each image is parsed
// by a transaction-level reference model that predicts the writes, the number
// of bytes taken from the FIFO and the final status.
// -----------------------------------------------------------------------------
module tb_boot_loader;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        reset;
    logic        restart  [2];
    logic        rx_valid [2];
    logic [7:0]  rx_data  [2];
    logic        rx_pop   [2];
    logic        we       [2];
    logic [31:0] wd       [2];
    logic        in_exec  [2];
    logic        lerr     [2];
    logic [15:0] wa0;
    logic [3:0]  wa1;
    logic [16:0] wl0;
    logic [4:0]  wl1;

    int compared   = 0;
    int mismatched = 0;

    wr_t expq0[$];
    wr_t expq1[$];
    wr_t mon_e0;
    wr_t mon_e1;

    boot_loader dut (
        .clk           (clk),
        .reset         (reset),
        .restart       (restart[0]),
        .rx_valid      (rx_valid[0]),
        .rx_data       (rx_data[0]),
        .rx_pop        (rx_pop[0]),
        .write_enable  (we[0]),
        .write_address (wa0),
        .write_data    (wd[0]),
        .in_execution  (in_exec[0]),
        .load_error    (lerr[0]),
        .words_loaded  (wl0)
    );

    boot_loader #(
        .WORD_BYTES (4),
        .ADDR_WIDTH (4),
        .BIG_ENDIAN (1'b0),
        .CHECKSUM   (1'b0)
    ) dut_small (
        .clk           (clk),
        .reset         (reset),
        .restart       (restart[1]),
        .rx_valid      (rx_valid[1]),
        .rx_data       (rx_data[1]),
        .rx_pop        (rx_pop[1]),
        .write_enable  (we[1]),
        .write_address (wa1),
        .write_data    (wd[1]),
        .in_execution  (in_exec[1]),
        .load_error    (lerr[1]),
        .words_loaded  (wl1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input longint got, input longint exp);
        compared++;
        if (got != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint get_wl(input int d);
        return (d == 0) ? longint'(wl0) : longint'(wl1);
    endfunction

    function automatic int pending(input int d);
        return (d == 0) ? expq0.size() : expq1.size();
    endfunction

    // Write monitor: every strobe must match the next predicted write.
    always @(negedge clk) begin
        if (we[0]) begin
            if (expq0.size() == 0) begin
                checkOutput("unexpected_write0", 1, 0);
            end else begin
                mon_e0 = expq0.pop_front();
                checkOutput("write0_addr", wa0, mon_e0.addr);
                checkOutput("write0_data", wd[0], mon_e0.data);
            end
        end
        if (we[1]) begin
            if (expq1.size() == 0) begin
                checkOutput("unexpected_write1", 1, 0);
            end else begin
                mon_e1 = expq1.pop_front();
                checkOutput("write1_addr", wa1, mon_e1.addr);
                checkOutput("write1_data", wd[1], mon_e1.data);
            end
        end
    end

    // Reference model: parse the framed image at transaction level.
    task automatic model_stream(input int d, input bq_t s, output int pops,
                                output bit run_ok, output bit err, output int wl);
        int          aw;
        bit          be;
        bit          cs;
        longint      n;
        longint      limit;
        logic [7:0]  sum;
        logic [7:0]  v;
        logic [31:0] word;
        wr_t         e;
        aw     = (d == 0) ? 16 : 4;
        be     = (d == 0);
        cs     = (d == 0);
        n      = longint'({s[0], s[1], s[2], s[3]});
        limit  = longint'(1) << aw;
        sum    = 8'h00;
        run_ok = 1'b0;
        err    = 1'b0;
        wl     = 0;
        if (n > limit) begin
            pops = 4;
            err  = 1'b1;
            return;
        end
        for (int w = 0; w < int'(n); w++) begin
            word = 32'h0;
            for (int b = 0; b < 4; b++) begin
                v   = s[4 + 4 * w + b];
                sum = sum + v;
                if (be) word = word | (32'(v) << (8 * (3 - b)));
                else    word = word | (32'(v) << (8 * b));
            end
            e.addr = w;
            e.data = word;
            if (d == 0) expq0.push_back(e);
            else        expq1.push_back(e);
        end
        pops = 4 + 4 * int'(n);
        wl   = int'(n);
        if (cs) begin
            if (s[pops] == sum) run_ok = 1'b1;
            else                err    = 1'b1;
            pops++;
        end else begin
            run_ok = 1'b1;
        end
    endtask

    // Header, random payload, optional checksum (0 none, 1 good, 2 bad), junk.
    function automatic bq_t build_stream(input logic [31:0] n, input int words, input int cs_mode);
        bq_t        s;
        logic [7:0] sum;
        logic [7:0] b;
        sum = 8'h00;
        for (int i = 0; i < 4; i++) s.push_back(n[31 - 8 * i -: 8]);
        for (int i = 0; i < 4 * words; i++) begin
            b   = 8'($urandom);
            sum = sum + b;
            s.push_back(b);
        end
        if (cs_mode == 1)      s.push_back(sum);
        else if (cs_mode == 2) s.push_back(sum + 8'h01);
        for (int i = 0; i < 3; i++) s.push_back(8'($urandom));
        return s;
    endfunction

    // Offer bytes with random gaps; stop once the loader refuses bytes for a
    // while or the stream is exhausted. Status is checked around the final pop.
    task automatic applyStimulus(input int d, input bq_t bytes, input int exp_pops,
                                 input bit exp_run, input bit exp_err, input int gap_pct);
        int idx       = 0;
        int idle      = 0;
        int cycles    = 0;
        bit just_done = 1'b0;
        while (idx < bytes.size() && idle < 8 && cycles < 3000) begin
            @(negedge clk);
            cycles++;
            if (just_done) begin
                checkOutput("in_execution_next", in_exec[d], exp_run);
                checkOutput("load_error_next", lerr[d], exp_err);
                just_done = 1'b0;
            end
            if ($urandom_range(99) < gap_pct) begin
                rx_valid[d] = 1'b0;
                rx_data[d]  = 8'($urandom);
            end else begin
                rx_valid[d] = 1'b1;
                rx_data[d]  = bytes[idx];
            end
            #1;
            checkOutput("pop_gated", rx_pop[d] & ~rx_valid[d], 0);
            if (rx_pop[d]) begin
                idx++;
                idle = 0;
                if (idx == exp_pops) begin
                    checkOutput("status_at_last_pop", in_exec[d] | lerr[d], 0);
                    just_done = 1'b1;
                end
            end else if (rx_valid[d]) begin
                idle++;
            end
        end
        @(negedge clk);
        rx_valid[d] = 1'b0;
        if (just_done) begin
            checkOutput("in_execution_next", in_exec[d], exp_run);
            checkOutput("load_error_next", lerr[d], exp_err);
        end
        checkOutput("bytes_popped", idx, exp_pops);
        checkOutput("stream_timeout", (cycles >= 3000) ? 1 : 0, 0);
    endtask

    task automatic restart_dut(input int d);
        @(negedge clk);
        restart[d] = 1'b1;
        @(negedge clk);
        restart[d] = 1'b0;
        #1;
        checkOutput("restart_words_loaded", get_wl(d), 0);
        checkOutput("restart_in_execution", in_exec[d], 0);
        checkOutput("restart_load_error", lerr[d], 0);
    endtask

    task automatic run_case(input int d, input bq_t s, input int gap_pct);
        int pops;
        int wl;
        bit run_ok;
        bit err;
        model_stream(d, s, pops, run_ok, err, wl);
        applyStimulus(d, s, pops, run_ok, err, gap_pct);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("words_loaded", get_wl(d), wl);
        checkOutput("in_execution", in_exec[d], run_ok);
        checkOutput("load_error", lerr[d], err);
        checkOutput("writes_outstanding", pending(d), 0);
        restart_dut(d);
    endtask

    initial begin
        bq_t         s;
        logic [31:0] n;
        wr_t         e;

        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            restart[d]  = 1'b0;
            rx_valid[d] = 1'b0;
            rx_data[d]  = 8'h00;
        end
        #2;
        checkOutput("reset_rx_pop", rx_pop[0], 0);
        checkOutput("reset_write_enable", we[0], 0);
        checkOutput("reset_write_address", wa0, 0);
        checkOutput("reset_write_data", wd[0], 0);
        checkOutput("reset_in_execution", in_exec[0], 0);
        checkOutput("reset_load_error", lerr[0], 0);
        checkOutput("reset_words_loaded", wl0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Two-word image with matching checksum
        s = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
              8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hB8, 8'h55, 8'h66};
        run_case(0, s, 0);
        // Same image with a wrong checksum
        s = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
              8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hB9, 8'h55, 8'h66};
        run_case(0, s, 20);
        // Empty image, checksum 00
        run_case(0, build_stream(32'd0, 0, 1), 20);
        // Oversize header
        run_case(0, build_stream(32'h0001_0001, 0, 0), 20);

        for (int i = 0; i < 6; i++) begin
            n = 32'($urandom_range(1, 4));
            run_case(0, build_stream(n, int'(n), ($urandom_range(3) == 0) ? 2 : 1), 30);
        end

        // Little-endian, no checksum, one word
        s = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h99, 8'h98};
        run_case(1, s, 0);
        run_case(1, build_stream(32'd17, 0, 0), 20);
        run_case(1, build_stream(32'd16, 16, 0), 20);
        for (int i = 0; i < 5; i++) begin
            n = 32'($urandom_range(0, 17));
            run_case(1, build_stream(n, (n > 32'd16) ? 0 : int'(n), 0), 30);
        end

        // Restart mid-payload with a byte waiting: one full word, half a word
        s = build_stream(32'd3, 0, 0);
        s = s[0:3];
        for (int i = 0; i < 6; i++) s.push_back(8'($urandom));
        e.addr = 0;
        e.data = {s[4], s[5], s[6], s[7]};
        expq0.push_back(e);
        applyStimulus(0, s, 10, 1'b0, 1'b0, 30);
        @(negedge clk);
        restart[0]  = 1'b1;
        rx_valid[0] = 1'b1;
        rx_data[0]  = 8'h00;
        #1;
        checkOutput("pop_during_restart", rx_pop[0], 0);
        @(negedge clk);
        restart[0]  = 1'b0;
        rx_valid[0] = 1'b0;
        #1;
        checkOutput("restart_mid_words_loaded", wl0, 0);
        checkOutput("restart_mid_outstanding", expq0.size(), 0);
        run_case(0, build_stream(32'd1, 1, 1), 30);

        // Asynchronous reset in the middle of the second word
        s = build_stream(32'd2, 0, 0);
        s = s[0:3];
        for (int i = 0; i < 6; i++) s.push_back(8'($urandom));
        e.addr = 0;
        e.data = {s[4], s[5], s[6], s[7]};
        expq0.push_back(e);
        applyStimulus(0, s, 10, 1'b0, 1'b0, 30);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_write_enable", we[0], 0);
        checkOutput("async_write_address", wa0, 0);
        checkOutput("async_write_data", wd[0], 0);
        checkOutput("async_in_execution", in_exec[0], 0);
        checkOutput("async_load_error", lerr[0], 0);
        checkOutput("async_words_loaded", wl0, 0);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("async_outstanding", expq0.size(), 0);
        run_case(0, build_stream(32'd2, 2, 1), 30);
        run_case(1, build_stream(32'd2, 2, 0), 30);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
